wb_regfile: RTL

Write-back stage and architectural register file; the consumer end of the MEM/WB pipeline register. It selects the write-back value and destination register, then commits the value to an 8 x 16 register file. It serves the two decode-stage read ports with same-cycle write bypass. It also tracks processor halt and exception status and counts retired instructions.

---
 rtl/wisc_pkg.sv | 44 ++++
 rtl/wb_regfile_rf_bank.sv | 53 +++++
 rtl/wb_regfile.sv | 122 ++++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared write-back definitions: opcode constants, Dst_reg encoding, write-back FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package wisc_pkg;

    // Opcodes with special meaning in the write-back stage.
    localparam logic [4:0] HALT_OP = 5'b00000;
    localparam logic [4:0] NOP_OP  = 5'b00001;

    // Destination register select (Dst_reg field from MEM/WB).
    localparam logic [1:0] DST_RD   = 2'b00;
    localparam logic [1:0] DST_RS   = 2'b01;
    localparam logic [1:0] DST_R7   = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    localparam int unsigned RF_DEPTH = 8;
    localparam int unsigned RF_AW    = 3;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        ERR  = 2'b10
    } wb_state_t;

    // Destination register number for a Dst_reg encoding. DST_NONE never
    // commits, so its value only shows up on wb_reg_o; RD is as good as any.
    function automatic logic [RF_AW-1:0] dst_sel(
        input logic [1:0]       dst,
        input logic [RF_AW-1:0] rd,
        input logic [RF_AW-1:0] rs
    );
        logic [RF_AW-1:0] r;
        r = rd;
        case (dst)
            DST_RD:  r = rd;
            DST_RS:  r = rs;
            DST_R7:  r = 3'd7;
            default: r = rd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_regfile_rf_bank.sv
// 8 x DW register storage with one write port and two bypassed read ports.
// Latency: write lands at the clock edge; reads are combinational, same-cycle bypass of the write.
// Backpressure: none; a write is accepted every cycle we_i is high.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low clear of all entries
//   we_i, waddr_i, wdata_i write port
//   raddr1_i/rdata1_o      read port 1 (bypassed)
//   raddr2_i/rdata2_o      read port 2 (bypassed)
module rf_bank
    import wisc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [RF_AW-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [RF_AW-1:0] raddr1_i,
    output logic [DW-1:0]    rdata1_o,
    input  logic [RF_AW-1:0] raddr2_i,
    output logic [DW-1:0]    rdata2_o
);

    logic [DW-1:0] mem_q [RF_DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Decode sees the value being written this cycle, not the stale entry.
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects WB value/destination, commits to the register file, tracks halt/exception, counts retires.
// Latency: commit lands at the edge ending the WB cycle (bypassed to reads same cycle); halted/err/retire_cnt registered, +1 cycle.
// Backpressure: none; one instruction consumed per cycle, ignored entirely once halted or in error.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   data_read, address                load data / ALU result from MEM/WB
//   RD, RS, opcode, Dst_reg, Mem_reg  instruction fields and WB controls
//   Reg_write, Excp                   write enable, exception flag
//   rd_addr1/2, rd_data1/2            decode read ports (combinational, bypassed)
//   wb_en_o, wb_reg_o, wb_data_o      write-back info for EX forwarding
//   halted, err, retire_cnt           status and retired instruction count
module wb_regfile
    import wisc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    data_read,
    input  logic [DW-1:0]    address,
    input  logic [RF_AW-1:0] RD,
    input  logic [RF_AW-1:0] RS,
    input  logic [4:0]       opcode,
    input  logic [1:0]       Dst_reg,
    input  logic             Mem_reg,
    input  logic             Reg_write,
    input  logic             Excp,
    input  logic [RF_AW-1:0] rd_addr1,
    input  logic [RF_AW-1:0] rd_addr2,
    output logic [DW-1:0]    rd_data1,
    output logic [DW-1:0]    rd_data2,
    output logic             wb_en_o,
    output logic [RF_AW-1:0] wb_reg_o,
    output logic [DW-1:0]    wb_data_o,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_state_t        state_q, state_d;
    logic             halted_q;
    logic             err_q;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic [DW-1:0]    wb_data;
    logic [RF_AW-1:0] wb_reg;
    logic             running;
    logic             transition;
    logic             commit;
    logic             count_en;

    // ------------------------------------------------------------------
    // Write-back selection
    // ------------------------------------------------------------------
    assign wb_data = Mem_reg ? data_read : address;
    assign wb_reg  = dst_sel(Dst_reg, RD, RS);

    assign running    = (state_q == RUN);
    // A halting or faulting instruction never writes its destination.
    assign transition = (opcode == HALT_OP) | Excp;
    // Gating with rst keeps the bypass from showing a write while reset is
    // held, so reads reflect the cleared file immediately.
    assign commit     = rst & Reg_write & (Dst_reg != DST_NONE) & running & ~transition;

    // The HALT instruction itself retires; a faulting one does not.
    assign count_en = running & (opcode != NOP_OP) & ~Excp;
    assign retire_d = retire_q + CNT_W'(count_en);

    // ------------------------------------------------------------------
    // FSM next state: exception wins over halt; HALT/ERR are absorbing.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (running) begin
            if (Excp) begin
                state_d = ERR;
            end else if (opcode == HALT_OP) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d != RUN);
            err_q    <= (state_d == ERR);
            retire_q <= retire_d;
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    rf_bank #(
        .DW (DW)
    ) u_rf_bank (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (commit),
        .waddr_i  (wb_reg),
        .wdata_i  (wb_data),
        .raddr1_i (rd_addr1),
        .rdata1_o (rd_data1),
        .raddr2_i (rd_addr2),
        .rdata2_o (rd_data2)
    );

    assign wb_en_o    = commit;
    assign wb_reg_o   = wb_reg;
    assign wb_data_o  = wb_data;
    assign halted     = halted_q;
    assign err        = err_q;
    assign retire_cnt = retire_q;

endmodule
